// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: MultiCycleCPU control unit sequencing fetch/decode/execute/mem/writeback.
// Define MCC_PERF_CNT_EN to add the cyc_cnt/instr_cnt performance counters.
module multicycle_control_fsm #(
    parameter int OPW = 6
`ifdef MCC_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           mem_to_reg,
    output logic           ir_write,
    output logic           reg_write,
    output logic           reg_dst,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     pc_source,
    output logic [1:0]     alu_op,
    output logic           illegal_op
`ifdef MCC_PERF_CNT_EN
    , output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);
    localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_EX, S_ADDI_WB
    } state_t;

    state_t state, next;
    logic   is_sw;

    // zero is consumed by the datapath through pc_write_cond
    logic unused_zero;
    assign unused_zero = zero;

    // opcode is only valid in DECODE, so remember lw/sw for MEM_ADDR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
            is_sw <= 1'b0;
        end else begin
            state <= next;
            if (state == S_DECODE) is_sw <= (opcode == OP_SW);
        end
    end

    always_comb begin
        next          = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_source     = 2'd0;
        alu_op        = 2'd0;
        illegal_op    = 1'b0;
        case (state)
            S_RESET: next = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                next      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_R:         next = S_EXEC;
                    OP_LW, OP_SW: next = S_MEM_ADDR;
                    OP_BEQ:       next = S_BRANCH;
                    OP_J:         next = S_JUMP;
                    OP_ADDI:      next = S_ADDI_EX;
                    default: begin
                        next       = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                next      = is_sw ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                next     = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next       = S_FETCH;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                next      = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                next      = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                next          = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                next      = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                next      = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                next      = S_FETCH;
            end
            default: next = S_RESET;
        endcase
    end

`ifdef MCC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else if (state != S_RESET) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (next == S_FETCH && state != S_FETCH) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: random opcode/mem_ready/reset stimulus checked against an
// instruction-phase model (class + cycle index within the instruction).
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;
    logic pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write;
    logic reg_write, reg_dst, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source, alu_op;
`ifdef MCC_PERF_CNT_EN
    logic [31:0] cyc_cnt, instr_cnt;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op), .illegal_op(illegal_op)
`ifdef MCC_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
    );

    logic [16:0] obs;
    assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write,
                  reg_write, reg_dst, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op};

    // instruction classes and their cycle counts with memory always ready
    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;
    int len [7] = '{4, 5, 4, 3, 3, 4, 2};
    logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] op);
        for (int i = 0; i < 6; i++) if (ops[i] == op) return i;
        return K_ILL;
    endfunction

    // ph: -1 reset, 0 fetch, 1 decode, 2.. execution steps of class k
    function automatic logic [16:0] expect_out(input int ph, input int k, input logic mr,
                                               input logic [5:0] op);
        logic pw = 0, pwc = 0, io = 0, rd = 0, wr = 0, m2r = 0, irw = 0, rw = 0, dst = 0, asa = 0, ill = 0;
        logic [1:0] asb = 0, ps = 0, aop = 0;
        if (ph == 0) begin
            rd = 1; asb = 1; irw = mr; pw = mr;
        end else if (ph == 1) begin
            asb = 3; ill = (classify(op) == K_ILL);
        end else if (ph == 2) begin
            if (k == K_R) begin asa = 1; aop = 2; end
            if (k == K_LW || k == K_SW || k == K_ADDI) begin asa = 1; asb = 2; end
            if (k == K_BEQ) begin asa = 1; aop = 1; pwc = 1; ps = 1; end
            if (k == K_J) begin pw = 1; ps = 2; end
        end else if (ph == 3) begin
            if (k == K_R) begin rw = 1; dst = 1; end
            if (k == K_LW) begin io = 1; rd = 1; end
            if (k == K_SW) begin io = 1; wr = 1; end
            if (k == K_ADDI) rw = 1;
        end else if (ph == 4 && k == K_LW) begin
            rw = 1; m2r = 1;
        end
        return {pw, pwc, io, rd, wr, m2r, irw, rw, dst, asa, asb, ps, aop, ill};
    endfunction

    initial begin
        int ph = -1, k = K_ILL, nph;
        longint cyc = 0, instr = 0;
        #1;
        check("reset_outputs", 64'(obs), 64'd0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n = !(c < 2 || $urandom_range(0, 99) < 2);
            opcode = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 5)] : 6'($urandom);
            mem_ready = $urandom_range(0, 9) < 7;
            zero = 1'($urandom);
            // the first stretch ties mem_ready high to exercise the nominal latencies
            if (c < 200) mem_ready = 1'b1;
            #1;
            check(rst_n ? "outputs" : "outputs_in_reset", 64'(obs),
                  64'(expect_out(rst_n ? ph : -1, k, mem_ready, opcode)));
            check("rd_wr_excl", 64'(mem_read & mem_write), 64'd0);
`ifdef MCC_PERF_CNT_EN
            check("cyc_cnt", 64'(cyc_cnt), rst_n ? 64'(cyc) : 64'd0);
            check("instr_cnt", 64'(instr_cnt), rst_n ? 64'(instr) : 64'd0);
`endif
            if (!rst_n) nph = -1;
            else if (ph == -1) nph = 0;
            else if (ph == 0) nph = mem_ready ? 1 : 0;
            else if (ph == 1) begin
                k = classify(opcode);
                nph = (len[k] == 2) ? 0 : 2;
            end else if (ph == 3 && (k == K_LW || k == K_SW) && !mem_ready) nph = 3;
            else nph = (ph + 1 == len[k]) ? 0 : ph + 1;
            if (!rst_n) begin
                cyc = 0; instr = 0;
            end else if (ph != -1) begin
                cyc = (cyc + 1) & 64'hFFFF_FFFF;
                if (ph > 0 && nph == 0) instr = (instr + 1) & 64'hFFFF_FFFF;
            end
            ph = nph;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
